pwm_ramp_ctrl: RTL and testbench

//  Duty-cycle sequencer for the 16-clock-period pwm block. On a start request it walks
//  the pwm duty from its current value to a requested target, one step per programmable

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_ramp_ctrl_if.sv | 24 ++
 rtl/pwm.sv | 36 +++
 rtl/pwm_ramp_ctrl.sv | 124 ++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm duty sequencer: duty limits, frame length,
// FSM state encoding and the duty-to-pwm-select mapping.
package pwm_pkg;

    localparam logic [3:0] DUTY_MIN  = 4'd2;
    localparam logic [3:0] DUTY_MAX  = 4'd14;
    localparam int         FRAME_LEN = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    // The pwm block encodes half duty (8 of 16) as select 0; every other legal
    // duty maps straight through. 1, 8 and 15 are never issued as selects.
    function automatic logic [3:0] duty_to_sel(input logic [3:0] duty);
        return (duty == 4'd8) ? 4'h0 : duty;
    endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Control/status bundle between a CPU register block and the duty sequencer.
interface pwm_ramp_ctrl_if #(
    parameter int DW = 8
);
    logic          start;
    logic [3:0]    target;
    logic [DW-1:0] step_dwell;
    logic          abort;
    logic [3:0]    duty;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, target, step_dwell, abort,
        input  duty, busy, done, err
    );

    modport slave (
        input  start, target, step_dwell, abort,
        output duty, busy, done, err
    );

endinterface

// File: rtl/pwm.sv
// 16-clock-period PWM generator. Select n gives n high clocks per frame, with
// n==0 meaning 8. The select is latched at the frame boundary so a duty change
// never produces a truncated or stretched pulse.
module pwm
    import pwm_pkg::*;
#(
    parameter logic [3:0] N_RST = 4'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] n,
    output logic       pwm_o
);

    logic [3:0] cnt;
    logic [3:0] n_q;
    logic [3:0] on_cnt;

    assign on_cnt = (n_q == 4'h0) ? 4'd8 : n_q;

    // Frame counter, frame-aligned select latch and registered waveform.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 4'd0;
            n_q   <= N_RST;
            pwm_o <= 1'b0;
        end else begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'(FRAME_LEN - 1)) begin
                n_q <= n;
            end
            pwm_o <= (cnt < on_cnt);
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer: on start, walks the pwm duty one on-clock at a time
// toward the requested target, one step every dwell_lim PWM frames.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int         DW       = 8,
    parameter logic [3:0] DUTY_RST = 4'd2
) (
    input  logic            clk,
    input  logic            reset_n,
    pwm_ramp_ctrl_if.slave  bus,
    output logic            pwm_o
);

    state_t        state_q, state_nx;
    logic [3:0]    frame_cnt;
    logic          tick;
    logic [3:0]    duty_q, duty_nx;
    logic [3:0]    tgt_q, tgt_nx;
    logic [DW-1:0] lim_q, lim_nx;
    logic [DW-1:0] dcnt_q, dcnt_nx;
    logic          done_q, done_nx;
    logic          err_q, err_nx;
    logic          busy_q;
    logic          legal;
    logic [3:0]    pwm_sel;

    assign tick  = (frame_cnt == 4'(FRAME_LEN - 1));
    assign legal = (bus.target >= DUTY_MIN) && (bus.target <= DUTY_MAX);

    assign bus.duty = duty_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

    assign pwm_sel = duty_to_sel(duty_q);

    // Free-running frame counter, aligned with the pwm instance's own frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= 4'd0;
        end else begin
            frame_cnt <= frame_cnt + 4'd1;
        end
    end

    // State, duty and ramp bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            duty_q  <= DUTY_RST;
            tgt_q   <= DUTY_RST;
            lim_q   <= DW'(1);
            dcnt_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            duty_q  <= duty_nx;
            tgt_q   <= tgt_nx;
            lim_q   <= lim_nx;
            dcnt_q  <= dcnt_nx;
            done_q  <= done_nx;
            err_q   <= err_nx;
            busy_q  <= (state_nx == RAMP);
        end
    end

    // Next-state logic: request acceptance in IDLE, dwell counting and duty
    // stepping in RAMP; abort wins over both tick and start.
    always_comb begin
        state_nx = state_q;
        duty_nx  = duty_q;
        tgt_nx   = tgt_q;
        lim_nx   = lim_q;
        dcnt_nx  = dcnt_q;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (!legal) begin
                        err_nx = 1'b1;
                    end else if (bus.target == duty_q) begin
                        done_nx = 1'b1;
                    end else begin
                        tgt_nx   = bus.target;
                        lim_nx   = (bus.step_dwell == '0) ? DW'(1) : bus.step_dwell;
                        dcnt_nx  = '0;
                        state_nx = RAMP;
                    end
                end
            end
            RAMP: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                end else if (tick) begin
                    if (dcnt_q + DW'(1) == lim_q) begin
                        dcnt_nx = '0;
                        duty_nx = (tgt_q > duty_q) ? duty_q + 4'd1 : duty_q - 4'd1;
                        if (duty_nx == tgt_q) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end
                    end else begin
                        dcnt_nx = dcnt_q + DW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    pwm #(
        .N_RST (duty_to_sel(DUTY_RST))
    ) u_pwm (
        .clk   (clk),
        .reset (!reset_n),
        .n     (pwm_sel),
        .pwm_o (pwm_o)
    );

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: reset state, up/down ramps with several
// dwell settings, rejected starts, abort and asynchronous reset mid-ramp.
module tb_pwm_ramp_ctrl;

    logic clk;
    logic reset_n;
    logic pwm_o;

    int checks   = 0;
    int failures = 0;

    pwm_ramp_ctrl_if #(.DW(8)) bus();

    pwm_ramp_ctrl #(
        .DW       (8),
        .DUTY_RST (4'd2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .pwm_o   (pwm_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic count_pwm(input int ncyc, output int highs);
        highs = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (pwm_o === 1'b1) highs++;
        end
    endtask

    // Issue a start and follow the ramp to done, checking step direction,
    // step spacing, select encoding, final state and total time.
    task automatic run_ramp(input string tag, input logic [3:0] tgt, input logic [7:0] dw);
        int lim, steps, cyc, nchg, last, budget, tot;
        bit ok_step, ok_int, ok_sel, seen;
        logic [3:0] prev, from;
        lim   = (dw == 8'd0) ? 1 : int'(dw);
        from  = bus.duty;
        steps = (tgt > from) ? int'(tgt - from) : int'(from - tgt);
        tot   = steps * lim;
        budget = tot * 16 + 20;
        ok_step = 1; ok_int = 1; ok_sel = 1; seen = 0;
        nchg = 0; cyc = 0; last = 0; prev = from;
        @(negedge clk);
        bus.start = 1'b1; bus.target = tgt; bus.step_dwell = dw;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.duty !== prev) begin
                if ((tgt > from) ? (bus.duty !== prev + 4'd1) : (bus.duty !== prev - 4'd1)) ok_step = 0;
                if (nchg > 0 && (cyc - last) != lim * 16) ok_int = 0;
                if (dut.pwm_sel !== ((bus.duty == 4'd8) ? 4'h0 : bus.duty)) ok_sel = 0;
                last = cyc;
                nchg++;
                prev = bus.duty;
            end
            if (bus.done === 1'b1) seen = 1;
        end
        chk({tag, "_done"},   32'(seen), 32'd1);
        chk({tag, "_steps"},  32'(nchg), 32'(steps));
        chk({tag, "_dir"},    32'(ok_step), 32'd1);
        chk({tag, "_spacing"},32'(ok_int), 32'd1);
        chk({tag, "_sel"},    32'(ok_sel), 32'd1);
        chk({tag, "_duty"},   32'(bus.duty), 32'(tgt));
        chk({tag, "_idle"},   32'(bus.busy), 32'd0);
        chk({tag, "_noerr"},  32'(bus.err), 32'd0);
        chk({tag, "_tmax"},   32'(cyc <= tot * 16), 32'd1);
        chk({tag, "_tmin"},   32'(cyc > (tot - 1) * 16), 32'd1);
        @(negedge clk);
        chk({tag, "_donepulse"}, 32'(bus.done), 32'd0);
    endtask

    // Start with an out-of-range target: expect a lone err pulse.
    task automatic bad_start(input string tag, input logic [3:0] tgt);
        logic [3:0] d0;
        d0 = bus.duty;
        @(negedge clk);
        bus.start = 1'b1; bus.target = tgt; bus.step_dwell = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_err"},  32'(bus.err), 32'd1);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_duty"}, 32'(bus.duty), 32'(d0));
        @(negedge clk);
        chk({tag, "_errpulse"}, 32'(bus.err), 32'd0);
        chk({tag, "_busy2"},    32'(bus.busy), 32'd0);
    endtask

    initial begin
        int highs, cyc, nchg, ndone, budget;
        logic [3:0] prev;
        bus.start = 1'b0;
        bus.target = 4'd2;
        bus.step_dwell = 8'd1;
        bus.abort = 1'b0;
        reset_n = 1'b0;

        // 1: reset state and idle waveform
        repeat (3) @(negedge clk);
        chk("rst_duty", 32'(bus.duty), 32'd2);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err",  32'(bus.err), 32'd0);
        chk("rst_pwm",  32'(pwm_o), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        count_pwm(32, highs);
        chk("rst_pwm_2of16", 32'(highs), 32'd4);

        // 2: ramp up 2 -> 6, one frame per step
        run_ramp("up6", 4'd6, 8'd1);
        repeat (16) @(negedge clk);
        count_pwm(32, highs);
        chk("up6_pwm_6of16", 32'(highs), 32'd12);

        // 3: 6 -> 10 then down to 4 with three frames per step, through duty 8
        run_ramp("up10", 4'd10, 8'd1);
        run_ramp("dn4", 4'd4, 8'd3);

        // 4: rejected targets, equal target, and dwell 0 treated as 1
        bad_start("t15", 4'd15);
        bad_start("t1", 4'd1);
        @(negedge clk);
        bus.start = 1'b1; bus.target = 4'd4; bus.step_dwell = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("eq_done", 32'(bus.done), 32'd1);
        chk("eq_err",  32'(bus.err), 32'd0);
        chk("eq_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("eq_donepulse", 32'(bus.done), 32'd0);
        run_ramp("dn2", 4'd2, 8'd1);
        run_ramp("dw0", 4'd5, 8'd0);

        // abort while idle changes nothing
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("idle_abort_duty", 32'(bus.duty), 32'd5);
        chk("idle_abort_busy", 32'(bus.busy), 32'd0);

        // 5: ramp 2 -> 12, retarget attempt ignored, abort after four steps
        run_ramp("dn2b", 4'd2, 8'd1);
        @(negedge clk);
        bus.start = 1'b1; bus.target = 4'd12; bus.step_dwell = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ab_busy", 32'(bus.busy), 32'd1);
        prev = bus.duty; nchg = 0; cyc = 0; budget = 4 * 16 + 20;
        while (nchg < 4 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.start) begin
                bus.start = 1'b0;
                chk("ab_ignore_err",  32'(bus.err), 32'd0);
                chk("ab_ignore_busy", 32'(bus.busy), 32'd1);
            end
            if (bus.duty !== prev) begin
                nchg++;
                prev = bus.duty;
                if (nchg == 1) begin
                    bus.start = 1'b1; bus.target = 4'd3;
                end
            end
        end
        chk("ab_four_steps", 32'(nchg), 32'd4);
        chk("ab_duty_pre", 32'(bus.duty), 32'd6);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("ab_busy_off", 32'(bus.busy), 32'd0);
        chk("ab_done_off", 32'(bus.done), 32'd0);
        chk("ab_duty",     32'(bus.duty), 32'd6);
        ndone = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        chk("ab_no_done",  32'(ndone), 32'd0);
        chk("ab_duty_hold", 32'(bus.duty), 32'd6);

        // 6: asynchronous reset in the middle of a ramp
        @(negedge clk);
        bus.start = 1'b1; bus.target = 4'd12; bus.step_dwell = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_duty", 32'(bus.duty), 32'd2);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_pwm",  32'(pwm_o), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ar_duty_rel", 32'(bus.duty), 32'd2);
        run_ramp("ar_up4", 4'd4, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
